// File: rtl/axi_mem_pkg.sv
// Shared AXI response/burst encodings and FSM state types for the axi_mem_slave slice.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package axi_mem_pkg;

    // AXI response codes
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // AXI burst types; 2'b11 is reserved
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;

    // Write-channel state machine
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    // Read-channel state machine
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rstate_t;

    // WRAP and reserved bursts share the upper encoding bit; both are
    // executed as INCR but flagged when the response check is built in.
    function automatic logic burst_unsupported(input logic [1:0] burst);
        return burst[1];
    endfunction

endpackage

// File: rtl/axi_mem_bram.sv
// Simple-dual-port word array: one byte-enabled write port, one registered read port.
// Latency: write lands on the clock edge; read data valid one cycle after re.
// Backpressure: none; rdata holds its value whenever re is low (read-first on collisions).
module axi_mem_bram #(
    parameter int AW = 12,
    parameter int DW = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW/8-1:0]   wbe,
    input  logic [DW-1:0]     wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Byte-enabled write; contents are never reset so they survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wbe[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read port; sampling the array with a non-blocking read
    // makes a same-cycle write to the same word return the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by an on-chip byte-enabled array; optional AXI_MEM_RESP_CHECK_EN adds SLVERR checks.
// Latency: WREADY one cycle after AW, BVALID one cycle after last W; RVALID two cycles after AR or each R beat.
// Backpressure: ready/valid on every channel, all decoded from registered state; B and R hold until accepted.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W     = 27,
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    // write address
    input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
    input  logic [7:0]            S_AXI_AWLEN,
    input  logic [2:0]            S_AXI_AWSIZE,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic                  S_AXI_AWLOCK,
    input  logic [3:0]            S_AXI_AWCACHE,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic [3:0]            S_AXI_AWQOS,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    // write data
    input  logic [DATA_W-1:0]     S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]   S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    // write response
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    // read address
    input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic [1:0]            S_AXI_ARLOCK,
    input  logic [3:0]            S_AXI_ARCACHE,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic [3:0]            S_AXI_ARQOS,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    // read data
    output logic [DATA_W-1:0]     S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);

    localparam int IDX_HI = DEPTH_LOG2 + 3;

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    wstate_t               wstate;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_fixed;
    logic [7:0]            w_cnt;
    logic [1:0]            b_resp;
    logic                  w_drop;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    rstate_t               rstate;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_fixed;
    logic [7:0]            r_cnt;
    logic [1:0]            r_resp;
    logic                  r_zero;

    // Error qualifiers evaluated at the address / data handshakes
    logic                  aw_oor;
    logic                  aw_err;
    logic                  wlast_err;
    logic                  ar_oor;
    logic                  ar_err;

`ifdef AXI_MEM_RESP_CHECK_EN
    assign aw_oor    = |S_AXI_AWADDR[ADDR_W-1:DEPTH_LOG2+4];
    assign aw_err    = aw_oor || (S_AXI_AWSIZE != 3'b100) || burst_unsupported(S_AXI_AWBURST);
    assign wlast_err = (S_AXI_WLAST != (w_cnt == 8'd0));
    assign ar_oor    = |S_AXI_ARADDR[ADDR_W-1:DEPTH_LOG2+4];
    assign ar_err    = ar_oor || (S_AXI_ARSIZE != 3'b100) || burst_unsupported(S_AXI_ARBURST);
`else
    // Unchecked build: addresses alias modulo depth and every burst is OKAY.
    assign aw_oor    = 1'b0;
    assign aw_err    = 1'b0;
    assign wlast_err = 1'b0;
    assign ar_oor    = 1'b0;
    assign ar_err    = 1'b0;
`endif

    // Sideband fields the responder deliberately ignores
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                         S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                         S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWSIZE, S_AXI_ARSIZE,
                         S_AXI_WLAST, S_AXI_AWBURST, S_AXI_ARBURST};

    // ------------------------------------------------------------------
    // Handshake outputs: pure decodes of registered state
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = (wstate == W_IDLE);
    assign S_AXI_WREADY  = (wstate == W_DATA);
    assign S_AXI_BVALID  = (wstate == W_RESP);
    assign S_AXI_BRESP   = b_resp;

    assign S_AXI_ARREADY = (rstate == R_IDLE);
    assign S_AXI_RVALID  = (rstate == R_DATA);
    assign S_AXI_RLAST   = (rstate == R_DATA) && (r_cnt == 8'd0);
    assign S_AXI_RRESP   = r_resp;

    // ------------------------------------------------------------------
    // Array
    // ------------------------------------------------------------------
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_q;

    assign mem_we = S_AXI_WREADY && S_AXI_WVALID && !w_drop;
    assign mem_re = (rstate == R_FETCH);

    axi_mem_bram #(
        .AW (DEPTH_LOG2),
        .DW (DATA_W)
    ) u_bram (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (w_idx),
        .wbe   (S_AXI_WSTRB),
        .wdata (S_AXI_WDATA),
        .re    (mem_re),
        .raddr (r_idx),
        .rdata (mem_q)
    );

    // The array output only reloads in R_FETCH, so RDATA is naturally
    // stable while a beat is stalled; out-of-range reads are forced to 0.
    assign S_AXI_RDATA = r_zero ? '0 : mem_q;

    // Write FSM: accept address, take LEN+1 beats, then hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate  <= W_IDLE;
            w_idx   <= '0;
            w_fixed <= 1'b0;
            w_cnt   <= 8'd0;
            b_resp  <= OKAY;
            w_drop  <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (S_AXI_AWVALID) begin
                        w_idx   <= S_AXI_AWADDR[IDX_HI:4];
                        w_fixed <= (S_AXI_AWBURST == FIXED);
                        w_cnt   <= S_AXI_AWLEN;
                        b_resp  <= aw_err ? SLVERR : OKAY;
                        w_drop  <= aw_oor;
                        wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (S_AXI_WVALID) begin
                        if (!w_fixed) begin
                            w_idx <= w_idx + 1'b1;
                        end
                        w_cnt <= w_cnt - 8'd1;
                        if (wlast_err) begin
                            b_resp <= SLVERR;
                        end
                        // The beat count, not WLAST, decides where the burst ends.
                        if (w_cnt == 8'd0) begin
                            wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: one fetch cycle per beat, then hold the beat until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate  <= R_IDLE;
            r_idx   <= '0;
            r_fixed <= 1'b0;
            r_cnt   <= 8'd0;
            r_resp  <= OKAY;
            r_zero  <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        r_idx   <= S_AXI_ARADDR[IDX_HI:4];
                        r_fixed <= (S_AXI_ARBURST == FIXED);
                        r_cnt   <= S_AXI_ARLEN;
                        r_resp  <= ar_err ? SLVERR : OKAY;
                        r_zero  <= ar_oor;
                        rstate  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rstate <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (r_cnt == 8'd0) begin
                            rstate <= R_IDLE;
                        end else begin
                            if (!r_fixed) begin
                                r_idx <= r_idx + 1'b1;
                            end
                            r_cnt  <= r_cnt - 8'd1;
                            rstate <= R_FETCH;
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave against a word-array reference model.
// Latency: checks WREADY/BVALID/RVALID cycle positions relative to each handshake.
// Backpressure: exercises RREADY stalls and BREADY hold, and rst mid-burst.
module tb_axi_mem_slave;

    localparam logic [1:0] R_OK  = 2'b00;
    localparam logic [1:0] R_ERR = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [26:0]  awaddr;  logic [7:0] awlen;  logic [2:0] awsize;  logic [1:0] awburst;
    logic         awvalid, awready;
    logic [127:0] wdata;   logic [15:0] wstrb; logic wlast, wvalid, wready;
    logic [1:0]   bresp;   logic bvalid, bready;
    logic [26:0]  araddr;  logic [7:0] arlen;  logic [2:0] arsize;  logic [1:0] arburst;
    logic         arvalid, arready;
    logic [127:0] rdata;   logic [1:0] rresp;  logic rlast, rvalid, rready;

    axi_mem_slave dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'h0), .S_AXI_AWPROT(3'h0), .S_AXI_AWQOS(4'h0),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARLOCK(2'b00), .S_AXI_ARCACHE(4'h0), .S_AXI_ARPROT(3'h0), .S_AXI_ARQOS(4'h0),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Beat buffers shared by drivers and the model
    logic [127:0] wd  [0:255];
    logic [15:0]  ws  [0:255];
    logic [127:0] rd  [0:255];
    logic         rl  [0:255];
    logic [127:0] erd [0:255];
    // Reference memory: one entry per 16-byte word
    logic [127:0] mm  [0:4095];

    // ---------------- reference model ----------------
    function automatic bit out_of_range(input logic [26:0] a);
`ifdef AXI_MEM_RESP_CHECK_EN
        return a[26:16] != 11'h0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] exp_resp(input logic [26:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input bit bad_last);
`ifdef AXI_MEM_RESP_CHECK_EN
        if (a[26:16] != 11'h0 || size != 3'd4 || burst >= 2'd2 || bad_last) return R_ERR;
        return R_OK;
`else
        return R_OK;
`endif
    endfunction

    task automatic model_write(input logic [26:0] a, input int len, input logic [1:0] burst);
        int w;
        w = int'(a[15:4]);
        if (out_of_range(a)) return;
        for (int i = 0; i <= len; i++) begin
            for (int b = 0; b < 16; b++)
                if (ws[i][b]) mm[w][8*b +: 8] = wd[i][8*b +: 8];
            if (burst != 2'b00) w = (w + 1) % 4096;
        end
    endtask

    task automatic model_read(input logic [26:0] a, input int len, input logic [1:0] burst);
        int w;
        w = int'(a[15:4]);
        for (int i = 0; i <= len; i++) begin
            erd[i] = out_of_range(a) ? 128'h0 : mm[w];
            if (burst != 2'b00) w = (w + 1) % 4096;
        end
    endtask

    // ---------------- bus drivers (inputs change and outputs are sampled on negedge) ----------------
    task automatic do_write(input logic [26:0] a, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input bit bad_last,
                            output bit wr_n1, output bit bv_m1, output logic [1:0] resp,
                            output bit aw_again, output bit ok);
        int t;
        ok = 1'b1;
        @(negedge clk);
        awaddr = a; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0; while (!awready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) ok = 1'b0;
        @(negedge clk);
        awvalid = 1'b0;
        wr_n1 = wready;
        for (int i = 0; i <= len; i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = (i == len) && !bad_last; wvalid = 1'b1;
            t = 0; while (!wready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) ok = 1'b0;
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bv_m1 = bvalid; resp = bresp;
        bready = 1'b1;
        t = 0; while (!bvalid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) ok = 1'b0;
        @(negedge clk);
        bready = 1'b0;
        aw_again = awready;
    endtask

    task automatic do_read(input logic [26:0] a, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input int stall_beat, input int stall_n,
                           output bit rv_n1, output bit rv_n2, output logic [1:0] resp,
                           output bit stable_ok, output bit gap_ok, output bit ok);
        int t;
        logic [127:0] sd;
        ok = 1'b1; stable_ok = 1'b1; gap_ok = 1'b1;
        @(negedge clk);
        araddr = a; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0; while (!arready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) ok = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        rv_n1 = rvalid;
        rready = 1'b1;
        @(negedge clk);
        rv_n2 = rvalid;
        resp = rresp;
        for (int i = 0; i <= len; i++) begin
            t = 0; while (!rvalid && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) ok = 1'b0;
            if (i == stall_beat) begin
                rready = 1'b0;
                sd = rdata;
                for (int k = 0; k < stall_n; k++) begin
                    @(negedge clk);
                    if (!rvalid || rdata !== sd || rlast !== (i == len)) stable_ok = 1'b0;
                end
                rready = 1'b1;
            end
            rd[i] = rdata; rl[i] = rlast; resp = rresp;
            @(negedge clk);
            if (i < len && rvalid) gap_ok = 1'b0;
        end
        rready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [9:0] got;
        rst = 1'b1;
        #2;
        got = {awready, arready, wready, bvalid, bresp, rvalid, rlast, rresp};
        n_cmp++;
        if (got !== 10'b11_0_0_00_0_0_00) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want %b", got, 10'b1100000000);
        end
        n_cmp++;
        if (rdata !== 128'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill;
        bit a, b, c, ok; logic [1:0] r;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 256; i++) begin
                wd[i] = {$urandom, $urandom, $urandom, $urandom};
                ws[i] = 16'hFFFF;
            end
            do_write({11'h0, 4'(k), 8'h00, 4'h0}, 255, 2'b01, 3'd4, 1'b0, a, b, r, c, ok);
            model_write({11'h0, 4'(k), 8'h00, 4'h0}, 255, 2'b01);
            n_cmp++;
            if (r !== R_OK || !ok || !b) begin
                n_fail++; $display("FAIL fill_%0d: resp %b ok %0d bvalid %0d want 00 1 1", k, r, ok, b);
            end
        end
    endtask

    task automatic test_single;
        bit wr1, bv1, awa, ok, rv1, rv2, st, gp, ok2; logic [1:0] r, rr;
        wd[0] = {96'h0123_4567_89AB_CDEF_0011_2233, 32'hDEADBEEF}; ws[0] = 16'hFFFF;
        do_write(27'h40, 0, 2'b01, 3'd4, 1'b0, wr1, bv1, r, awa, ok);
        model_write(27'h40, 0, 2'b01);
        n_cmp++; if ({wr1, bv1, awa, ok} !== 4'b1111) begin
            n_fail++; $display("FAIL single_wr_timing: wready@N+1 %0d bvalid@M+1 %0d awready_after_b %0d ok %0d want 1111", wr1, bv1, awa, ok); end
        n_cmp++; if (r !== R_OK) begin n_fail++; $display("FAIL single_bresp: got %b want 00", r); end
        do_read(27'h40, 0, 2'b01, 3'd4, -1, 0, rv1, rv2, rr, st, gp, ok2);
        n_cmp++; if ({rv1, rv2, ok2} !== 3'b011) begin
            n_fail++; $display("FAIL single_rd_timing: rvalid@N+1 %0d rvalid@N+2 %0d ok %0d want 011", rv1, rv2, ok2); end
        n_cmp++; if (rd[0] !== wd[0]) begin n_fail++; $display("FAIL single_rdata: got %h want %h", rd[0], wd[0]); end
        n_cmp++; if (rl[0] !== 1'b1 || rr !== R_OK) begin
            n_fail++; $display("FAIL single_rlast_rresp: rlast %b rresp %b want 1 00", rl[0], rr); end
    endtask

    task automatic test_incr_stall;
        bit wr1, bv1, awa, ok, rv1, rv2, st, gp, ok2; logic [1:0] r, rr;
        for (int i = 0; i < 4; i++) begin wd[i] = 128'(i + 1); ws[i] = 16'hFFFF; end
        do_write(27'h100, 3, 2'b01, 3'd4, 1'b0, wr1, bv1, r, awa, ok);
        model_write(27'h100, 3, 2'b01);
        do_read(27'h100, 3, 2'b01, 3'd4, 1, 3, rv1, rv2, rr, st, gp, ok2);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd[i] !== 128'(i + 1) || rl[i] !== (i == 3)) begin
                n_fail++; $display("FAIL incr_beat%0d: data %h last %b want %h %b", i, rd[i], rl[i], 128'(i + 1), (i == 3));
            end
        end
        n_cmp++; if (!st) begin n_fail++; $display("FAIL incr_stall_stable: stable %0d want 1", st); end
        n_cmp++; if (!gp || !ok2 || !bv1) begin
            n_fail++; $display("FAIL incr_gap: gap_ok %0d ok %0d bvalid %0d want 1 1 1", gp, ok2, bv1); end
    endtask

    task automatic test_strobe;
        bit wr1, bv1, awa, ok, rv1, rv2, st, gp, ok2; logic [1:0] r, rr;
        logic [127:0] want;
        want = {{120{1'b1}}, 8'h00};
        wd[0] = {128{1'b1}}; ws[0] = 16'hFFFF;
        do_write(27'h300, 0, 2'b01, 3'd4, 1'b0, wr1, bv1, r, awa, ok);
        model_write(27'h300, 0, 2'b01);
        wd[0] = 128'h0; ws[0] = 16'h0001;
        do_write(27'h300, 0, 2'b01, 3'd4, 1'b0, wr1, bv1, r, awa, ok);
        model_write(27'h300, 0, 2'b01);
        do_read(27'h300, 0, 2'b01, 3'd4, -1, 0, rv1, rv2, rr, st, gp, ok2);
        n_cmp++; if (rd[0] !== want) begin n_fail++; $display("FAIL strobe: got %h want %h", rd[0], want); end
    endtask

    task automatic test_fixed_wrap;
        bit wr1, bv1, awa, ok, rv1, rv2, st, gp, ok2; logic [1:0] r, rr;
        logic [127:0] nb;
        nb = mm[12'h021];
        for (int i = 0; i < 3; i++) begin wd[i] = 128'(i + 7); ws[i] = 16'hFFFF; end
        do_write(27'h200, 2, 2'b00, 3'd4, 1'b0, wr1, bv1, r, awa, ok);
        model_write(27'h200, 2, 2'b00);
        do_read(27'h200, 1, 2'b01, 3'd4, -1, 0, rv1, rv2, rr, st, gp, ok2);
        n_cmp++; if (rd[0] !== 128'd9) begin n_fail++; $display("FAIL fixed_word: got %h want 9", rd[0]); end
        n_cmp++; if (rd[1] !== nb) begin n_fail++; $display("FAIL fixed_neighbor: got %h want %h", rd[1], nb); end
        wd[0] = 128'hA5A5; wd[1] = 128'h5A5A; ws[0] = 16'hFFFF; ws[1] = 16'hFFFF;
        do_write(27'hFFF0, 1, 2'b01, 3'd4, 1'b0, wr1, bv1, r, awa, ok);
        model_write(27'hFFF0, 1, 2'b01);
        do_read(27'hFFF0, 1, 2'b01, 3'd4, -1, 0, rv1, rv2, rr, st, gp, ok2);
        n_cmp++; if (rd[0] !== 128'hA5A5 || rd[1] !== 128'h5A5A) begin
            n_fail++; $display("FAIL wrap: got %h %h want a5a5 5a5a", rd[0], rd[1]); end
    endtask

    task automatic test_alias;
        bit wr1, bv1, awa, ok, rv1, rv2, st, gp, ok2; logic [1:0] r, rr;
        model_read(27'h4000000, 0, 2'b01);
        do_read(27'h4000000, 0, 2'b01, 3'd4, -1, 0, rv1, rv2, rr, st, gp, ok2);
        n_cmp++; if (rr !== exp_resp(27'h4000000, 3'd4, 2'b01, 1'b0)) begin
            n_fail++; $display("FAIL alias_rresp: got %b want %b", rr, exp_resp(27'h4000000, 3'd4, 2'b01, 1'b0)); end
        n_cmp++; if (rd[0] !== erd[0]) begin n_fail++; $display("FAIL alias_rdata: got %h want %h", rd[0], erd[0]); end
        wd[0] = 128'hBAD0_0BAD; ws[0] = 16'hFFFF;
        do_write(27'h4000050, 0, 2'b01, 3'd4, 1'b0, wr1, bv1, r, awa, ok);
        model_write(27'h4000050, 0, 2'b01);
        n_cmp++; if (r !== exp_resp(27'h4000050, 3'd4, 2'b01, 1'b0)) begin
            n_fail++; $display("FAIL alias_bresp: got %b want %b", r, exp_resp(27'h4000050, 3'd4, 2'b01, 1'b0)); end
        do_read(27'h50, 0, 2'b01, 3'd4, -1, 0, rv1, rv2, rr, st, gp, ok2);
        n_cmp++; if (rd[0] !== mm[5]) begin n_fail++; $display("FAIL alias_drop: got %h want %h", rd[0], mm[5]); end
        wd[0] = 128'h77; wd[1] = 128'h88; ws[0] = 16'hFFFF; ws[1] = 16'hFFFF;
        do_write(27'h600, 1, 2'b01, 3'd4, 1'b1, wr1, bv1, r, awa, ok);
        model_write(27'h600, 1, 2'b01);
        n_cmp++; if (r !== exp_resp(27'h600, 3'd4, 2'b01, 1'b1) || !awa) begin
            n_fail++; $display("FAIL wlast_resp: got %b awready %0d want %b 1", r, awa, exp_resp(27'h600, 3'd4, 2'b01, 1'b1)); end
    endtask

    task automatic test_random;
        bit wr1, bv1, awa, ok, rv1, rv2, st, gp, ok2, bad; logic [1:0] r, rr, bu;
        logic [26:0] a; logic [2:0] sz; int len;
        for (int it = 0; it < 30; it++) begin
            a   = {($urandom % 8 == 0) ? 11'($urandom_range(1, 2047)) : 11'h0, 12'($urandom), 4'($urandom)};
            len = $urandom_range(0, 7);
            bu  = 2'($urandom);
            sz  = ($urandom % 8 == 0) ? 3'($urandom_range(0, 3)) : 3'd4;
            bad = ($urandom % 10 == 0);
            for (int i = 0; i <= len; i++) begin
                wd[i] = {$urandom, $urandom, $urandom, $urandom};
                ws[i] = 16'($urandom);
            end
            do_write(a, len, bu, sz, bad, wr1, bv1, r, awa, ok);
            model_write(a, len, bu);
            n_cmp++; if (r !== exp_resp(a, sz, bu, bad) || !ok || !bv1) begin
                n_fail++; $display("FAIL rnd_bresp_%0d: got %b ok %0d want %b", it, r, ok, exp_resp(a, sz, bu, bad)); end
            a   = {($urandom % 8 == 0) ? 11'($urandom_range(1, 2047)) : 11'h0, 12'($urandom), 4'($urandom)};
            len = $urandom_range(0, 7);
            bu  = 2'($urandom);
            sz  = ($urandom % 8 == 0) ? 3'($urandom_range(0, 3)) : 3'd4;
            model_read(a, len, bu);
            do_read(a, len, bu, sz, $urandom_range(0, 7), $urandom_range(0, 3), rv1, rv2, rr, st, gp, ok2);
            n_cmp++; if (rr !== exp_resp(a, sz, bu, 1'b0) || !ok2 || !st || !gp) begin
                n_fail++; $display("FAIL rnd_rresp_%0d: got %b ok %0d stable %0d gap %0d want %b", it, rr, ok2, st, gp, exp_resp(a, sz, bu, 1'b0)); end
            for (int i = 0; i <= len; i++) begin
                n_cmp++;
                if (rd[i] !== erd[i] || rl[i] !== (i == len)) begin
                    n_fail++; $display("FAIL rnd_rdata_%0d_%0d: got %h last %b want %h %b", it, i, rd[i], rl[i], erd[i], (i == len));
                end
            end
        end
    endtask

    task automatic test_rst_midburst;
        bit rv1, rv2, st, gp, ok2; logic [1:0] rr; int t; logic [4:0] got;
        @(negedge clk);
        araddr = 27'h100; arlen = 8'd3; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b1;
        t = 0; while (!arready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            t = 0; while (!rvalid && t < 50) begin @(negedge clk); t++; end
            @(negedge clk);
        end
        t = 0; while (!rvalid && t < 50) begin @(negedge clk); t++; end
        n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_rvalid: got %b want 1", rvalid); end
        rready = 1'b0;
        #1 rst = 1'b1;
        #1 got = {rvalid, rlast, wready, bvalid, arready};
        n_cmp++; if (got !== 5'b00001 || awready !== 1'b1) begin
            n_fail++; $display("FAIL rst_async: rvalid/rlast/wready/bvalid/arready %b awready %b want 00001 1", got, awready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (arready !== 1'b1 || rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rst_release: arready %b rvalid %b want 1 0", arready, rvalid); end
        do_read(27'h40, 0, 2'b01, 3'd4, -1, 0, rv1, rv2, rr, st, gp, ok2);
        n_cmp++; if (rd[0] !== mm[4] || !ok2) begin
            n_fail++; $display("FAIL rst_mem_kept: got %h want %h", rd[0], mm[4]); end
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awlen = '0; awsize = 3'd4; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
        test_reset;
        test_fill;
        test_single;
        test_incr_stall;
        test_strobe;
        test_fixed_wrap;
        test_alias;
        test_random;
        test_rst_midburst;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 slave responder that terminates the 128-bit DRAM-side master port of the core (27-bit address, INCR/FIXED bursts) with an on-chip byte-enabled memory. It serves as the DDR stand-in for simulation and for small-footprint FPGA builds, wired port-for-port to the core's `M_AXI_*` signals. Read and write channels run as independent state machines over a simple-dual-port array.

## Interface
- `ADDR_W`, 27: AXI byte address width.
- `DATA_W`, 128: data width; strobe width is `DATA_W/8`.
- `DEPTH_LOG2`, 12: log2 of the number of 16-byte words.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `S_AXI_AWADDR`/`AWLEN`/`AWSIZE`/`AWBURST` in 27/8/3/2: write address, beats-1, size, burst type.
- `S_AXI_AWLOCK`/`AWCACHE`/`AWPROT`/`AWQOS` in 1/4/3/4: ignored.
- `S_AXI_AWVALID` in 1; `S_AXI_AWREADY` out 1: write address handshake.
- `S_AXI_WDATA`/`WSTRB`/`WLAST` in 128/16/1: write beat.
- `S_AXI_WVALID` in 1; `S_AXI_WREADY` out 1: write data handshake.
- `S_AXI_BRESP` out 2; `S_AXI_BVALID` out 1; `S_AXI_BREADY` in 1: write response.
- `S_AXI_ARADDR`/`ARLEN`/`ARSIZE`/`ARBURST` in 27/8/3/2: read address.
- `S_AXI_ARLOCK`/`ARCACHE`/`ARPROT`/`ARQOS` in 2/4/3/4: ignored.
- `S_AXI_ARVALID` in 1; `S_AXI_ARREADY` out 1: read address handshake.
- `S_AXI_RDATA`/`RRESP`/`RLAST` out 128/2/1; `S_AXI_RVALID` out 1; `S_AXI_RREADY` in 1: read data.

## Operation
- Word index is `ADDR[DEPTH_LOG2+3:4]`. Low 4 address bits are ignored.
- INCR: the word index increments per beat, wrapping modulo 2^DEPTH_LOG2. FIXED: the index holds. Reserved and WRAP bursts are treated as INCR.
- Write FSM has states W_IDLE, W_DATA and W_RESP.
  - W_IDLE: AWREADY=1. On the AW handshake, latch the index and burst type, set the beat counter to AWLEN, and go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the bytes whose WSTRB bit is 1, advances the index and decrements the counter.
  - The last beat is the beat with counter==0. It moves the FSM to W_RESP regardless of WLAST.
  - W_RESP: BVALID=1 with the latched BRESP. Hold until BREADY, then go to W_IDLE.
- Read FSM has states R_IDLE, R_FETCH and R_DATA.
  - R_IDLE: ARREADY=1. On the AR handshake, latch the index, burst type and ARLEN, and go to R_FETCH.
  - R_FETCH: present the index to the read port, then go to R_DATA.
  - R_DATA: RVALID=1. RDATA comes from the registered array output. RLAST=(counter==0). RDATA, RRESP and RLAST are stable while RVALID && !RREADY.
  - On the R handshake: if RLAST, go to R_IDLE; otherwise advance the index, decrement the counter and go to R_FETCH.
- A read and a write to the same word in the same cycle return the old data (read-first).
- Without the response check, BRESP and RRESP are always OKAY (2'b00).
- `rst` mid-burst:
  - Both FSMs go to idle immediately.
  - BVALID, RVALID, WREADY and RLAST go to 0; AWREADY and ARREADY go to 1.
  - The burst is abandoned with no response. Memory contents are preserved.

## Timing
- Reset values:
  - AWREADY=1, ARREADY=1.
  - WREADY=0, BVALID=0, BRESP=0.
  - RVALID=0, RLAST=0, RRESP=0, RDATA=0.
- All ready/valid outputs are decoded from registered state only. There are no combinational paths from inputs.
- AW handshake at cycle N: WREADY=1 from N+1. Last W beat at cycle M: BVALID=1 at M+1. Earliest next AWREADY is the cycle after the B handshake.
- AR handshake at cycle N: RVALID=1 at N+2. A non-last beat accepted at K gives the next RVALID at K+2, so sustained throughput is one beat per 2 cycles.
- Write data is visible to a read issued in R_FETCH at or after cycle M+1.

## Configuration
- `AXI_MEM_RESP_CHECK_EN`, when defined, enables the response check. A burst gets SLVERR (2'b10) in BRESP/RRESP when any of these holds:
  - `ADDR[ADDR_W-1:DEPTH_LOG2+4]` is nonzero;
  - SIZE is not 3'b100;
  - BURST is WRAP or reserved;
  - on writes, WLAST disagrees with counter==0 on any beat.
- An out-of-range write is dropped (no array write). An out-of-range read returns RDATA=0. Beat counts and timing are unchanged.
- When the macro is undefined, no checks are made, responses are always OKAY, and addresses alias modulo depth.

## Structure
- Package `axi_mem_pkg` holds:
  - response constants OKAY and SLVERR;
  - burst constants FIXED, INCR and WRAP;
  - enums `wstate_t` and `rstate_t`.
- Sub-module `axi_mem_bram` is a simple-dual-port array: one write port with 16 byte enables, one registered read port, read-first, no reset on contents.

## Test plan
- Single write: AW addr 0x40, len 0, WDATA 0x..DEADBEEF, WSTRB all ones -> WREADY at N+1, BVALID at M+1 with OKAY. Then AR 0x40 len 0 -> RDATA 0x..DEADBEEF, RLAST=1 at N+2.
- INCR burst: write len 3 at 0x100 with data 1..4, read back len 3 -> four beats of 1..4, RLAST only on the 4th. Hold RREADY=0 for 3 cycles on beat 2 -> RDATA stays 2.
- Byte strobes: write 0xFF..FF, then WSTRB=16'h0001 with data 0 -> read returns 0xFF..FF00.
- FIXED burst len 2 writing 7, 8, 9 at 0x200 -> a read of 0x200 returns 9. Wrap case: INCR at the last word, len 1 -> the second beat lands at word 0.
- With `AXI_MEM_RESP_CHECK_EN`: AR at 0x4000000 -> RRESP=SLVERR, RDATA=0. Without it -> RRESP=OKAY, aliased data.
- Assert `rst` during beat 2 of a 4-beat read -> RVALID=0 in the same cycle. After release, ARREADY=1, and an earlier-written word is still intact on read.
